// File: rtl/pwm_pkg.sv
// Shared widths, settings record, alignment-mode constants and counter direction for pwm_bank.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W   = 16;
    localparam int unsigned PWM_PRESC_W = 16;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    // Timebase settings at the default widths.
    typedef struct packed {
        logic [PWM_PRESC_W-1:0] prescale;
        logic [PWM_CNT_W-1:0]   period;
        logic                   center;
    } pwm_settings_t;

    typedef enum logic {
        DirUp,
        DirDown
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: active duty/polarity, compare against the shared counter, registered pin.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             apply,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty_pend,
    input  logic             pol_pend,
    output logic             pwm_out
);

    logic [CNT_W-1:0] duty_q;
    logic             pol_q;
    logic             out_d;
    logic             out_q;

    // A disabled bank drives low regardless of polarity.
    always_comb begin
        out_d = enable && ((cnt < duty_q) ^ pol_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_q <= '0;
            pol_q  <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            if (apply) begin
                duty_q <= duty_pend;
                pol_q  <= pol_pend;
            end
            out_q <= out_d;
        end
    end

    assign pwm_out = out_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: shared prescaler and edge/center-aligned period counter, with
// double-buffered settings that switch over only on a period boundary.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = PWM_CNT_W,
    parameter int unsigned PRESC_W  = PWM_PRESC_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic [CNT_W-1:0]          period,
    input  logic [CHANNELS*CNT_W-1:0] duty,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic                      center,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick,
    output logic                      update_pending
);

    typedef struct packed {
        logic [PRESC_W-1:0] prescale;
        logic [CNT_W-1:0]   period;
        logic               center;
    } settings_t;

    settings_t                 pend_q;
    settings_t                 act_q;
    logic [CHANNELS*CNT_W-1:0] duty_pend_q;
    logic [CHANNELS-1:0]       pol_pend_q;
    logic                      upd_q, upd_d;
    logic [PRESC_W-1:0]        presc_q, presc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    dir_e                      dir_q, dir_d;
    logic                      tick;
    logic                      boundary;
    logic                      apply;
    logic                      period_tick_q;

    always_comb begin
        presc_d  = '0;
        cnt_d    = '0;
        dir_d    = DirUp;
        boundary = 1'b0;
        tick     = enable && (presc_q == act_q.prescale);
        if (enable) begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            cnt_d   = cnt_q;
            dir_d   = dir_q;
            if (tick) begin
                if (act_q.center == PWM_EDGE) begin
                    if (cnt_q >= act_q.period) begin
                        cnt_d    = '0;
                        dir_d    = DirUp;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    unique case (dir_q)
                        DirUp: begin
                            // A zero period never leaves the bottom, so every tick is a boundary.
                            if (act_q.period == '0) begin
                                boundary = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                                if (cnt_d >= act_q.period) begin
                                    dir_d = DirDown;
                                end
                            end
                        end
                        DirDown: begin
                            if (cnt_q <= CNT_W'(1)) begin
                                cnt_d    = '0;
                                dir_d    = DirUp;
                                boundary = 1'b1;
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                    endcase
                end
            end
        end
        // A load coinciding with the switch-over stays pending for the next boundary.
        apply = upd_q && (boundary || !enable);
        upd_d = load || (upd_q && !apply);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q       <= '0;
            cnt_q         <= '0;
            dir_q         <= DirUp;
            upd_q         <= 1'b0;
            period_tick_q <= 1'b0;
            pend_q        <= '0;
            act_q         <= '0;
            duty_pend_q   <= '0;
            pol_pend_q    <= '0;
        end else begin
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            upd_q         <= upd_d;
            period_tick_q <= boundary;
            if (load) begin
                pend_q.prescale <= prescale;
                pend_q.period   <= period;
                pend_q.center   <= center;
                duty_pend_q     <= duty;
                pol_pend_q      <= polarity;
            end
            if (apply) begin
                act_q <= pend_q;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .enable   (enable),
            .apply    (apply),
            .cnt      (cnt_q),
            .duty_pend(duty_pend_q[i*CNT_W +: CNT_W]),
            .pol_pend (pol_pend_q[i]),
            .pwm_out  (pwm_out[i])
        );
    end

    assign period_tick    = period_tick_q;
    assign update_pending = upd_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: phase-based reference model compared every cycle,
// directed scenarios with hand-computed counts, then randomized settings traffic.
module tb_pwm_bank;

    localparam int CH = 4;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          load;
    logic [15:0]   prescale;
    logic [15:0]   period;
    logic [CH*16-1:0] duty;
    logic [CH-1:0] polarity;
    logic          center;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic          update_pending;

    pwm_bank #(
        .CHANNELS(CH),
        .CNT_W   (16),
        .PRESC_W (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .load          (load),
        .prescale      (prescale),
        .period        (period),
        .duty          (duty),
        .polarity      (polarity),
        .center        (center),
        .pwm_out       (pwm_out),
        .period_tick   (period_tick),
        .update_pending(update_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the period is tracked as elapsed ticks (phase);
    // the counter value is derived from the phase and the alignment mode.
    int            m_sub, m_phase;
    int            a_presc, a_per, p_presc, p_per;
    bit            a_ctr, p_ctr, m_upd;
    int            a_duty[CH], p_duty[CH];
    bit            a_pol[CH], p_pol[CH];
    logic [CH-1:0] e_pwm;
    logic          e_tick, e_upd;

    task automatic model_reset();
        m_sub = 0; m_phase = 0; m_upd = 0;
        a_presc = 0; a_per = 0; a_ctr = 0; p_presc = 0; p_per = 0; p_ctr = 0;
        for (int i = 0; i < CH; i++) begin
            a_duty[i] = 0; a_pol[i] = 0; p_duty[i] = 0; p_pol[i] = 0;
        end
        e_pwm = '0; e_tick = 1'b0; e_upd = 1'b0;
    endtask

    task automatic model_step();
        int c, len;
        bit tk, bnd, app;
        c = a_ctr ? ((m_phase <= a_per) ? m_phase : 2 * a_per - m_phase) : m_phase;
        for (int i = 0; i < CH; i++) e_pwm[i] = enable && ((c < a_duty[i]) ^ a_pol[i]);
        len = a_ctr ? ((a_per == 0) ? 1 : 2 * a_per) : a_per + 1;
        tk  = enable && (m_sub == a_presc);
        bnd = tk && (m_phase + 1 >= len);
        app = m_upd && (bnd || !enable);
        e_tick = bnd;
        if (!enable) begin
            m_sub = 0; m_phase = 0;
        end else begin
            m_sub = tk ? 0 : m_sub + 1;
            if (tk) m_phase = bnd ? 0 : m_phase + 1;
        end
        if (app) begin
            a_presc = p_presc; a_per = p_per; a_ctr = p_ctr;
            for (int i = 0; i < CH; i++) begin a_duty[i] = p_duty[i]; a_pol[i] = p_pol[i]; end
        end
        m_upd = load || (m_upd && !app);
        e_upd = m_upd;
        if (load) begin
            p_presc = int'(prescale); p_per = int'(period); p_ctr = center;
            for (int i = 0; i < CH; i++) begin
                p_duty[i] = int'(duty[i*16 +: 16]); p_pol[i] = polarity[i];
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
        #1;
        check("pwm_out", 32'(pwm_out), 32'(e_pwm));
        check("period_tick", 32'(period_tick), 32'(e_tick));
        check("update_pending", 32'(update_pending), 32'(e_upd));
    end

    int win_hi[CH];
    int win_tk;

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic count_window(input int n);
        for (int i = 0; i < CH; i++) win_hi[i] = 0;
        win_tk = 0;
        repeat (n) begin
            @(posedge clk); #3;
            for (int i = 0; i < CH; i++) win_hi[i] += int'(pwm_out[i]);
            win_tk += int'(period_tick);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin @(posedge clk); #3; n++; end while (!period_tick && n < 500);
        check("tick_seen", 32'(period_tick), 32'd1);
    endtask

    function automatic logic [CH*16-1:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic do_load(input int pre, input int per, input logic ctr,
                           input logic [CH*16-1:0] dv, input logic [CH-1:0] pv);
        prescale = 16'(pre); period = 16'(per); center = ctr; duty = dv; polarity = pv;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    int n, h;

    initial begin
        rst = 1'b0; enable = 1'b0; load = 1'b0; prescale = '0; period = '0;
        duty = '0; polarity = '0; center = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);

        // Reset mid-run with outputs high and an update pending.
        do_load(0, 20, 1'b0, pack4(0, 0, 0, 0), 4'hF);
        step(1);
        enable = 1'b1;
        step(5);
        #1 check("pre_reset_pwm", 32'(pwm_out), 32'hF);
        do_load(0, 20, 1'b0, pack4(5, 5, 5, 5), 4'h0);
        #3 rst = 1'b0;
        #2;
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        check("reset_upd", 32'(update_pending), 32'd0);
        @(posedge clk); #2 rst = 1'b1;

        // Edge mode, period 9.
        enable = 1'b0;
        do_load(0, 9, 1'b0, pack4(0, 3, 10, 12), 4'h0);
        step(1);
        enable = 1'b1;
        step(2);
        count_window(20);
        check("edge_ch0_high", win_hi[0], 0);
        check("edge_ch1_high", win_hi[1], 6);
        check("edge_ch2_high", win_hi[2], 20);
        check("edge_ch3_high", win_hi[3], 20);
        check("edge_ticks", win_tk, 2);

        // Center mode, prescale 1, period 4: counter 0..4..1 per 16 clk.
        do_load(1, 4, 1'b1, pack4(2, 2, 2, 2), 4'h0);
        step(30);
        wait_tick(n);
        wait_tick(n);
        check("center_period_clk", n, 16);
        count_window(32);
        check("center_ch0_high", win_hi[0], 12);
        check("center_ticks", win_tk, 2);

        // Duty change mid-period and on the boundary cycle.
        do_load(0, 9, 1'b0, pack4(3, 3, 3, 3), 4'h0);
        wait_tick(n);
        count_window(4);
        h = win_hi[0];
        duty = pack4(7, 7, 7, 7); load = 1'b1;
        @(posedge clk); #3 load = 1'b0;
        h += int'(pwm_out[0]);
        check("mid_load_pending", 32'(update_pending), 32'd1);
        count_window(5);
        check("old_period_high", h + win_hi[0], 3);
        check("applied_at_boundary", 32'(update_pending), 32'd0);
        count_window(9);
        check("new_period_high", win_hi[0], 7);
        duty = pack4(1, 1, 1, 1); load = 1'b1;
        @(posedge clk); #3 load = 1'b0;
        h = int'(pwm_out[0]);
        check("bnd_load_pending", 32'(update_pending), 32'd1);
        count_window(5);
        h += win_hi[0];
        check("bnd_load_still_pending", 32'(update_pending), 32'd1);
        count_window(5);
        check("bnd_load_keeps_old", h + win_hi[0], 7);
        count_window(10);
        check("bnd_load_applied", win_hi[0], 1);

        // Disabled bank: immediate apply, forced-low outputs, full first period.
        enable = 1'b0;
        step(1);
        do_load(0, 9, 1'b0, pack4(3, 3, 3, 3), 4'hF);
        #1 check("dis_upd_pulse", 32'(update_pending), 32'd1);
        step(1);
        #1 check("dis_upd_clear", 32'(update_pending), 32'd0);
        check("dis_pwm_low", 32'(pwm_out), 32'd0);
        do_load(0, 5, 1'b0, pack4(3, 3, 3, 3), 4'hF);
        step(1);
        enable = 1'b1;
        wait_tick(n);
        check("first_period_clk", n, 6);
        wait_tick(n);
        check("second_period_clk", n, 6);

        // Zero period: constant level, tick every prescale+1 clk.
        do_load(2, 0, 1'b0, pack4(1, 1, 1, 1), 4'h0);
        step(20);
        count_window(12);
        check("p0_high", win_hi[0], 12);
        check("p0_ticks", win_tk, 4);
        do_load(2, 0, 1'b0, pack4(1, 1, 1, 1), 4'hF);
        step(6);
        count_window(12);
        check("p0_inv_high", win_hi[0], 0);
        check("p0_inv_ticks", win_tk, 4);

        // Randomized settings traffic, enable toggling and one asynchronous reset.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            load = ($urandom_range(0, 9) == 0);
            if (load) begin
                prescale = 16'($urandom_range(0, 3));
                period   = 16'($urandom_range(0, 12));
                center   = 1'($urandom_range(0, 1));
                duty     = pack4($urandom_range(0, 14), $urandom_range(0, 14),
                                 $urandom_range(0, 14), $urandom_range(0, 14));
                polarity = 4'($urandom_range(0, 15));
            end
            if (k == 750) begin
                #3 rst = 1'b0;
                #10 rst = 1'b1;
            end
            step(1);
        end
        load = 1'b0;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
